fifo_access_ctrl: RTL and testbench

Controller that sits in front of the width-converting FIFO (2*DATA_WIDTH-bit writes, DATA_WIDTH-bit reads) and lets NUM_WR producers share its write port.
- Write side: round-robin arbitration with bounded bursts.
- Read side: gates consumer pops against empty.
- Flush: a sequencer that drains the FIFO on command.
- Statistics: saturating counters for bring-up and debug.

---
 rtl/fifo_ctrl_pkg.sv | 27 ++
 rtl/fifo_access_ctrl_rr_pick.sv | 32 +++
 rtl/fifo_access_ctrl.sv | 155 +++++++++++++++
 tb/tb_fifo_access_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO access controller.
// State encoding, write-width helper and index-width function.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int WR_WIDTH       = 2 * DEF_DATA_WIDTH;

    function automatic int wr_width(input int dw);
        return 2 * dw;
    endfunction

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_access_ctrl_rr_pick.sv
// Rotate-priority picker: first requester at or after ptr.
// Purely combinational; grant is one-hot or zero.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    int j;

    // scan circularly from ptr, keep the first hit
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Write-port arbiter, read gate, flush sequencer and stats
// for a width-converting FIFO shared by NUM_WR producers.
module fifo_access_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_WR     = 2,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_WR-1:0]            req,
    input  logic [NUM_WR*2*DATA_WIDTH-1:0] w_data_in,
    output logic [NUM_WR-1:0]            ack,
    input  logic                         rd_req,
    output logic                         rd_ack,
    output logic [DATA_WIDTH-1:0]        rd_data,
    input  logic                         flush,
    output logic                         flush_done,
    output logic                         busy,
    output logic                         fifo_wr,
    output logic [2*DATA_WIDTH-1:0]      fifo_w_data,
    output logic                         fifo_rd,
    input  logic                         fifo_full,
    input  logic                         fifo_empty,
    input  logic [DATA_WIDTH-1:0]        fifo_r_data,
    output logic [CNT_WIDTH-1:0]         wr_cnt,
    output logic [CNT_WIDTH-1:0]         rd_cnt,
    output logic [CNT_WIDTH-1:0]         stall_cnt
);

    localparam int W  = wr_width(DATA_WIDTH);
    localparam int PW = clog2_min1(NUM_WR);
    localparam int BW = clog2_min1(BURST_LEN + 1);
    localparam logic [PW-1:0] LAST = PW'(NUM_WR - 1);
    localparam logic [BW-1:0] BEAT_END = BW'(BURST_LEN - 1);

    state_t          state, state_nx;
    logic [PW-1:0]   rr_ptr, rr_nx;
    logic [PW-1:0]   owner, owner_nx;
    logic [BW-1:0]   beat, beat_nx;
    logic [PW-1:0]   sel;
    logic            stall;

    logic [NUM_WR-1:0] pick_gnt;
    logic [PW-1:0]     pick_idx;
    logic              pick_any;

    rr_pick #(.N(NUM_WR), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
        return (i == LAST) ? '0 : i + PW'(1);
    endfunction

    // next state, grants, read gating and flush sequencing
    always_comb begin
        state_nx   = state;
        rr_nx      = rr_ptr;
        owner_nx   = owner;
        beat_nx    = beat;
        ack        = '0;
        sel        = '0;
        stall      = 1'b0;
        flush_done = 1'b0;
        rd_ack     = rd_req & ~fifo_empty;
        fifo_rd    = rd_req & ~fifo_empty;
        unique case (state)
            IDLE: begin
                if (flush) begin
                    state_nx = FLUSH;
                end else if (pick_any && !fifo_full) begin
                    ack      = pick_gnt;
                    sel      = pick_idx;
                    owner_nx = pick_idx;
                    beat_nx  = BW'(1);
                    if (BURST_LEN == 1) rr_nx = nxt(pick_idx);
                    else state_nx = BURST;
                end else if (pick_any) begin
                    stall = 1'b1;
                end
            end
            BURST: begin
                sel = owner;
                if (flush) begin
                    state_nx = FLUSH;
                end else if (!req[owner]) begin
                    rr_nx    = nxt(owner);
                    state_nx = IDLE;
                end else if (fifo_full) begin
                    stall = 1'b1;
                end else begin
                    ack[owner] = 1'b1;
                    beat_nx    = beat + BW'(1);
                    if (beat == BEAT_END) begin
                        rr_nx    = nxt(owner);
                        state_nx = IDLE;
                    end
                end
            end
            FLUSH: begin
                rd_ack  = 1'b0;
                fifo_rd = ~fifo_empty;
                if (fifo_empty) begin
                    flush_done = 1'b1;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign fifo_wr     = |ack;
    assign fifo_w_data = fifo_wr ? w_data_in[int'(sel)*W +: W] : '0;
    assign rd_data     = fifo_r_data;
    assign busy        = (state != IDLE);

    // FSM and arbitration registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            beat   <= '0;
        end else begin
            state  <= state_nx;
            rr_ptr <= rr_nx;
            owner  <= owner_nx;
            beat   <= beat_nx;
        end
    end

    // saturating statistics counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (fifo_wr && wr_cnt != '1)
                wr_cnt <= wr_cnt + CNT_WIDTH'(1);
            if (fifo_rd && rd_cnt != '1)
                rd_cnt <= rd_cnt + CNT_WIDTH'(1);
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Directed bench for fifo_access_ctrl with default parameters.
// Inputs change 1ns after posedge; outputs sampled 1ns later.
module tb_fifo_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] w_data_in;
    logic [1:0]  ack;
    logic        rd_req, rd_ack;
    logic [3:0]  rd_data;
    logic        flush, flush_done, busy;
    logic        fifo_wr, fifo_rd;
    logic [7:0]  fifo_w_data;
    logic        fifo_full, fifo_empty;
    logic [3:0]  fifo_r_data;
    logic [7:0]  wr_cnt, rd_cnt, stall_cnt;

    int nvec = 0;
    int nerr = 0;

    fifo_access_ctrl #(
        .DATA_WIDTH(4), .NUM_WR(2), .BURST_LEN(4), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .w_data_in(w_data_in),
        .ack(ack), .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
        .flush(flush), .flush_done(flush_done), .busy(busy),
        .fifo_wr(fifo_wr), .fifo_w_data(fifo_w_data), .fifo_rd(fifo_rd),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_r_data(fifo_r_data), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b0; req = 2'b00; w_data_in = 16'h0;
        rd_req = 1'b0; flush = 1'b0; fifo_full = 1'b0;
        fifo_empty = 1'b1; fifo_r_data = 4'h0;
        tick(); tick();
        settle();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_wr", 32'(fifo_wr), 32'h0);
        chk("rst_rd", 32'(fifo_rd), 32'h0);
        chk("rst_rdack", 32'(rd_ack), 32'h0);
        chk("rst_fdone", 32'(flush_done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cnts", {8'h0, wr_cnt, rd_cnt, stall_cnt}, 32'h0);
        reset = 1'b1;
        tick();

        // single writer, bubble exit
        req = 2'b01; w_data_in = 16'h0012;
        settle();
        chk("t1_ack0", 32'(ack), 32'h1);
        chk("t1_d0", 32'(fifo_w_data), 32'h12);
        tick();
        w_data_in = 16'h0034;
        settle();
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_ack1", 32'(ack), 32'h1);
        chk("t1_d1", 32'(fifo_w_data), 32'h34);
        tick();
        req = 2'b00;
        settle();
        chk("t1_bub_ack", 32'(ack), 32'h0);
        chk("t1_bub_wr", 32'(fifo_wr), 32'h0);
        chk("t1_bub_d", 32'(fifo_w_data), 32'h0);
        tick();
        chk("t1_idle", 32'(busy), 32'h0);
        chk("t1_rr", 32'(dut.rr_ptr), 32'h1);
        chk("t1_wrcnt", 32'(wr_cnt), 32'd2);

        // contention: rr_ptr=1, so requester 1 bursts first
        req = 2'b11; w_data_in = 16'hB1A0;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("t2_ack", 32'(ack), (i < 4) ? 32'h2 : 32'h1);
            chk("t2_d", 32'(fifo_w_data), (i < 4) ? 32'hB1 : 32'hA0);
            tick();
        end
        req = 2'b00;
        settle();
        chk("t2_idle", 32'(busy), 32'h0);
        chk("t2_rr", 32'(dut.rr_ptr), 32'h1);
        chk("t2_wrcnt", 32'(wr_cnt), 32'd10);
        tick();

        // back-pressure mid-burst on requester 1
        req = 2'b10; w_data_in = 16'h5600;
        settle();
        chk("t3_ack0", 32'(ack), 32'h2);
        tick();
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t3_full_wr", 32'(fifo_wr), 32'h0);
            chk("t3_full_busy", 32'(busy), 32'h1);
            tick();
        end
        fifo_full = 1'b0;
        chk("t3_owner", 32'(dut.owner), 32'h1);
        chk("t3_beat", 32'(dut.beat), 32'h1);
        chk("t3_stall", 32'(stall_cnt), 32'd3);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t3_resume", 32'(ack), 32'h2);
            tick();
        end
        req = 2'b00;
        settle();
        chk("t3_idle", 32'(busy), 32'h0);
        chk("t3_wrcnt", 32'(wr_cnt), 32'd14);
        chk("t3_rr", 32'(dut.rr_ptr), 32'h0);
        tick();

        // simultaneous read/write on empty FIFO
        req = 2'b01; rd_req = 1'b1; fifo_empty = 1'b1;
        w_data_in = 16'h0077;
        settle();
        chk("t4_wr", 32'(fifo_wr), 32'h1);
        chk("t4_rdack0", 32'(rd_ack), 32'h0);
        chk("t4_rd0", 32'(fifo_rd), 32'h0);
        tick();
        req = 2'b00; fifo_empty = 1'b0; fifo_r_data = 4'h9;
        settle();
        chk("t4_rdack1", 32'(rd_ack), 32'h1);
        chk("t4_rd1", 32'(fifo_rd), 32'h1);
        chk("t4_rdata", 32'(rd_data), 32'h9);
        tick();
        rd_req = 1'b0;
        settle();
        chk("t4_rdcnt", 32'(rd_cnt), 32'd1);
        chk("t4_wrcnt", 32'(wr_cnt), 32'd15);

        // flush issued during a burst, FIFO holds 5 entries
        req = 2'b10; w_data_in = 16'hC300;
        settle();
        chk("t5_ack", 32'(ack), 32'h2);
        tick();
        flush = 1'b1;
        settle();
        chk("t5_fl_ack", 32'(ack), 32'h0);
        chk("t5_fl_wr", 32'(fifo_wr), 32'h0);
        tick();
        flush = 1'b0; rd_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t5_pop", 32'(fifo_rd), 32'h1);
            chk("t5_rdack", 32'(rd_ack), 32'h0);
            chk("t5_noack", 32'(ack), 32'h0);
            chk("t5_nodone", 32'(flush_done), 32'h0);
            tick();
        end
        fifo_empty = 1'b1;
        settle();
        chk("t5_done", 32'(flush_done), 32'h1);
        chk("t5_nopop", 32'(fifo_rd), 32'h0);
        tick();
        req = 2'b00; rd_req = 1'b0;
        settle();
        chk("t5_idle", 32'(busy), 32'h0);
        chk("t5_rdcnt", 32'(rd_cnt), 32'd6);
        chk("t5_wrcnt", 32'(wr_cnt), 32'd16);

        // flush on an already-empty FIFO
        flush = 1'b1;
        tick();
        flush = 1'b0;
        settle();
        chk("t5e_busy", 32'(busy), 32'h1);
        chk("t5e_done", 32'(flush_done), 32'h1);
        tick();
        chk("t5e_idle", 32'(busy), 32'h0);

        // reset mid-burst with owner 1
        req = 2'b10;
        tick();
        chk("t6_busy", 32'(busy), 32'h1);
        chk("t6_owner", 32'(dut.owner), 32'h1);
        reset = 1'b0; req = 2'b11;
        tick();
        reset = 1'b1;
        settle();
        chk("t6_idle", 32'(busy), 32'h0);
        chk("t6_rr", 32'(dut.rr_ptr), 32'h0);
        chk("t6_cnts", {8'h0, wr_cnt, rd_cnt, stall_cnt}, 32'h0);
        chk("t6_grant", 32'(ack), 32'h1);

        // wr_cnt saturation
        req = 2'b01;
        for (int i = 0; i < 300; i++) tick();
        chk("sat_wrcnt", 32'(wr_cnt), 32'hFF);
        req = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
